// File: rtl/stream_arb_mux_if.sv
// Bundle of the N:1 stream mux channel inputs, their ready returns and the registered output stream.
interface stream_arb_mux_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_last;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_last;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    // master: channel producers plus downstream consumer; slave: the mux itself
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_arb_mux.sv
// N:1 valid/ready stream mux with round-robin or fixed-priority arbitration,
// packet lock for multi-beat transfers and a registered single-cycle output stage.
//
//   state  | meaning
//   IDLE   | between packets; any valid channel may win arbitration
//   LOCKED | mid-packet; only lock_q may transfer until its last beat
module stream_arb_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter bit RR_EN  = 1'b1
) (
    input logic             clk,
    input logic             reset,
    stream_arb_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam int CW    = SEL_W + 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic [CW-1:0]    sum;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] rr_win;
    logic             rr_found;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic             grant_in_vld;
    logic             load_en;
    logic             xfer;

    // Search from ptr with wrap; ptr stays 0 in fixed-priority mode so index 0 leads.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum = {1'b0, ptr_q} + CW'(k);
            if (sum >= CW'(NUM_IN)) sum = sum - CW'(NUM_IN);
            idx = sum[SEL_W-1:0];
            if (!rr_found && bus.in_valid[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
        end
    end

    always_comb begin
        grant     = rr_win;
        grant_vld = rr_found;
        if (state_q == LOCKED) begin
            grant     = lock_q;
            grant_vld = 1'b1;
        end
    end

    always_comb begin
        grant_data   = '0;
        grant_last   = 1'b0;
        grant_in_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data   = bus.in_data[i*WIDTH +: WIDTH];
                grant_last   = bus.in_last[i];
                grant_in_vld = bus.in_valid[i];
            end
        end
    end

    assign load_en = !valid_q || bus.out_ready;
    assign xfer    = load_en && grant_vld && grant_in_vld;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            bus.in_ready[i] = load_en && grant_vld && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        sel_d   = sel_q;
        if (xfer) begin
            data_d  = grant_data;
            last_d  = grant_last;
            sel_d   = grant;
            valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (!grant_last) begin
                        state_d = LOCKED;
                        lock_d  = grant;
                    end
                end
                LOCKED: begin
                    if (grant_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (RR_EN && grant_last) begin
                ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_sel   = sel_q;
endmodule
